// File: rtl/l2_bus_pkg.sv
// Shared definitions for the L2 bus arbiters: FSM encoding, request types and default burst length.
package l2_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } arb_state_e;

   localparam logic REQ_SINGLE = 1'b0;
   localparam logic REQ_BURST  = 1'b1;

   localparam int BURST_BEATS_DEF = 4;

endpackage

// File: rtl/l2_bus_arbiter_picker.sv
// Combinational rotating-priority picker: first set request at or after start_i, wrapping modulo NUM_MASTERS.
module rr_priority_picker #(
   parameter int NUM_MASTERS = 3,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]       start_i,
   output logic [NUM_MASTERS-1:0] grant_oh_o,
   output logic [IDX_W-1:0]       grant_idx_o,
   output logic                   any_o
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // NOTE: every output and temporary gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = int'(start_i) + i;
         if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
         cand_idx = IDX_W'(cand);
         if (!any_o && req_i[cand_idx]) begin
            any_o                = 1'b1;
            grant_oh_o[cand_idx] = 1'b1;
            grant_idx_o          = cand_idx;
         end
      end
   end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin owner arbiter for one tri-state L2 bus segment, with a forced
// dead (TURN) cycle between owners and a tenure watchdog.
module l2_bus_arbiter
   import l2_bus_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int OWNER_WIDTH = 2,
   parameter int BURST_BEATS = BURST_BEATS_DEF,
   parameter int MAX_TENURE  = 64
) (
   input  logic                   plusclk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] bus_req,
   input  logic [NUM_MASTERS-1:0] bus_req_type,
   input  logic [NUM_MASTERS-1:0] bus_hold,
   output logic [NUM_MASTERS-1:0] bus_grant,
   output logic                   bus_active,
   output logic [OWNER_WIDTH-1:0] bus_owner,
   output logic                   arb_timeout
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int TW    = $clog2(MAX_TENURE + 1);

   typedef logic [TW-1:0] tenure_t;

   localparam tenure_t TENURE_MAX = tenure_t'(MAX_TENURE);
   localparam tenure_t SINGLE_LEN = tenure_t'(1);
   localparam tenure_t BURST_LEN  = tenure_t'(BURST_BEATS + 1);

   arb_state_e             state_q,   state_d;
   logic [NUM_MASTERS-1:0] grant_q,   grant_d;
   logic                   active_q,  active_d;
   logic [OWNER_WIDTH-1:0] owner_q,   owner_d;
   tenure_t                min_len_q, min_len_d;
   tenure_t                tenure_q,  tenure_d;
   logic                   timeout_q, timeout_d;
   logic [IDX_W-1:0]       ptr_q,     ptr_d;

   logic [NUM_MASTERS-1:0] pick_oh;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;
   logic                   pick_type;
   logic                   owner_hold;
   logic                   forced;
   logic                   release_ok;

   rr_priority_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) u_picker (
      .req_i       (bus_req),
      .start_i     (ptr_q),
      .grant_oh_o  (pick_oh),
      .grant_idx_o (pick_idx),
      .any_o       (pick_any)
   );

   // Owner's hold/type bits are selected through the one-hot vectors rather than by index.
   assign pick_type  = |(pick_oh & bus_req_type);
   assign owner_hold = |(grant_q & bus_hold);
   assign forced     = (tenure_q == TENURE_MAX);
   assign release_ok = forced || ((tenure_q >= min_len_q) && !owner_hold);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of process order.
   always_ff @(posedge plusclk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         active_q  <= 1'b0;
         owner_q   <= '0;
         min_len_q <= '0;
         tenure_q  <= '0;
         timeout_q <= 1'b0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         active_q  <= active_d;
         owner_q   <= owner_d;
         min_len_q <= min_len_d;
         tenure_q  <= tenure_d;
         timeout_q <= timeout_d;
         ptr_q     <= ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      active_d  = active_q;
      owner_d   = owner_q;
      min_len_d = min_len_q;
      tenure_d  = tenure_q;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      unique case (state_q)
         ST_IDLE, ST_TURN: begin
            // TURN arbitrates exactly like IDLE; only the bus stays dark for that one cycle.
            grant_d  = '0;
            active_d = 1'b0;
            state_d  = ST_IDLE;
            if (pick_any) begin
               state_d   = ST_GRANT;
               grant_d   = pick_oh;
               active_d  = 1'b1;
               owner_d   = OWNER_WIDTH'(pick_idx);
               min_len_d = (pick_type == REQ_SINGLE) ? SINGLE_LEN : BURST_LEN;
               tenure_d  = tenure_t'(1);
               ptr_d     = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
            end
         end
         ST_GRANT: begin
            if (release_ok) begin
               state_d   = ST_TURN;
               grant_d   = '0;
               active_d  = 1'b0;
               timeout_d = forced;
            end else if (!forced) begin
               tenure_d = tenure_q + tenure_t'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            active_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      bus_grant   = grant_q;
      bus_active  = active_q;
      bus_owner   = owner_q;
      arb_timeout = timeout_q;
   end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Self-checking bench for l2_bus_arbiter: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a transaction-level ownership model.
module tb_l2_bus_arbiter;

   localparam int N      = 3;
   localparam int BEATS  = 4;
   localparam int MAXTEN = 64;

   logic         plusclk;
   logic         rst;
   logic [N-1:0] bus_req;
   logic [N-1:0] bus_req_type;
   logic [N-1:0] bus_hold;
   logic [N-1:0] bus_grant;
   logic         bus_active;
   logic [1:0]   bus_owner;
   logic         arb_timeout;

   int n_cmp;
   int n_bad;

   // Model: who owns the bus, how long it has owned it, and where the next search starts.
   int m_idx;
   int m_len;
   int m_min;
   int m_ptr;
   int m_owner;
   bit m_to;

   l2_bus_arbiter #(
      .NUM_MASTERS (N),
      .OWNER_WIDTH (2),
      .BURST_BEATS (BEATS),
      .MAX_TENURE  (MAXTEN)
   ) dut (
      .plusclk      (plusclk),
      .rst          (rst),
      .bus_req      (bus_req),
      .bus_req_type (bus_req_type),
      .bus_hold     (bus_hold),
      .bus_grant    (bus_grant),
      .bus_active   (bus_active),
      .bus_owner    (bus_owner),
      .arb_timeout  (arb_timeout)
   );

   initial plusclk = 1'b0;
   always #5 plusclk = ~plusclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // A released owner first leaves the bus dark for one edge; arbitration then happens
   // on the following edge exactly as it would from idle.
   function automatic void model_step();
      bit found;
      if (rst) begin
         m_idx = -1; m_len = 0; m_min = 0; m_ptr = 0; m_owner = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (m_idx >= 0) begin
            if (m_len == MAXTEN || (m_len >= m_min && !bus_hold[m_idx])) begin
               m_to  = (m_len == MAXTEN);
               m_idx = -1;
            end else begin
               m_len++;
            end
         end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (!found && bus_req[c]) begin
                  found   = 1;
                  m_idx   = c;
                  m_owner = c;
                  m_len   = 1;
                  m_min   = bus_req_type[c] ? BEATS + 1 : 1;
                  m_ptr   = (c + 1) % N;
               end
            end
         end
      end
   endfunction

   task automatic cycle();
      logic [N-1:0] exp_grant;
      @(posedge plusclk);
      model_step();
      @(negedge plusclk);
      exp_grant = (m_idx >= 0) ? N'(1 << m_idx) : '0;
      check("grant",   bus_grant,   exp_grant);
      check("active",  bus_active,  (m_idx >= 0));
      check("owner",   bus_owner,   m_owner);
      check("timeout", arb_timeout, m_to);
   endtask

   initial begin
      logic [N-1:0] fair_seq [7];
      n_cmp = 0; n_bad = 0;
      m_idx = -1; m_len = 0; m_min = 0; m_ptr = 0; m_owner = 0; m_to = 0;
      rst = 1'b1; bus_req = '0; bus_req_type = '0; bus_hold = '0;
      cycle(); cycle();
      check("rst_grant", bus_grant, 3'b000);
      check("rst_active", bus_active, 1'b0);
      check("rst_owner", bus_owner, 2'd0);
      check("rst_timeout", arb_timeout, 1'b0);
      rst = 1'b0;

      // Two single-beat requesters, one turnaround between them.
      bus_req = 3'b011;
      cycle(); check("t1_g0", bus_grant, 3'b001);
      bus_req = 3'b010;
      cycle(); check("t1_turn", bus_grant, 3'b000); check("t1_turn_act", bus_active, 1'b0);
      cycle(); check("t1_g1", bus_grant, 3'b010); check("t1_own1", bus_owner, 2'd1);
      bus_req = 3'b000;
      cycle(); check("t1_turn2", bus_grant, 3'b000);
      cycle(); check("t1_idle", bus_grant, 3'b000);

      // Burst tenure without hold: five grant cycles.
      bus_req = 3'b100; bus_req_type = 3'b100;
      cycle(); check("t2_g", bus_grant, 3'b100); check("t2_own", bus_owner, 2'd2);
      bus_req = '0; bus_req_type = '0;
      for (int g = 2; g <= 5; g++) begin
         cycle(); check("t2_g", bus_grant, 3'b100);
      end
      cycle(); check("t2_dead", bus_grant, 3'b000);

      // Burst extended by hold to eight cycles while requester 0 waits.
      bus_req = 3'b100; bus_req_type = 3'b100; bus_hold = 3'b100;
      cycle(); check("t3_g1", bus_grant, 3'b100);
      bus_req = 3'b001; bus_req_type = 3'b000;
      for (int g = 2; g <= 8; g++) begin
         cycle(); check("t3_hold", bus_grant, 3'b100);
      end
      bus_hold = 3'b000;
      cycle(); check("t3_turn", bus_grant, 3'b000);
      cycle(); check("t3_next", bus_grant, 3'b001);
      bus_req = '0;
      cycle(); cycle();

      // Stuck hold: watchdog release after MAX_TENURE cycles.
      bus_req = 3'b010; bus_hold = 3'b010;
      cycle(); check("t4_g1", bus_grant, 3'b010);
      bus_req = 3'b001;
      for (int g = 2; g <= MAXTEN; g++) begin
         cycle(); check("t4_held", bus_grant, 3'b010);
      end
      cycle(); check("t4_turn", bus_grant, 3'b000); check("t4_to", arb_timeout, 1'b1);
      cycle(); check("t4_next", bus_grant, 3'b001); check("t4_to_off", arb_timeout, 1'b0);
      bus_hold = '0; bus_req = '0;
      cycle(); cycle();

      // Fairness from a fresh reset.
      rst = 1'b1; cycle(); rst = 1'b0;
      fair_seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      bus_req = 3'b111;
      for (int s = 0; s < 7; s++) begin
         cycle(); check("t5_fair", bus_grant, fair_seq[s]);
      end
      bus_req = '0;

      // Reset mid-burst drops the grant with no turnaround and no timeout.
      rst = 1'b1; cycle(); rst = 1'b0;
      bus_req = 3'b001; bus_req_type = 3'b001;
      cycle(); bus_req = '0;
      cycle(); cycle(); check("t6_b3", bus_grant, 3'b001);
      rst = 1'b1; bus_req = 3'b111; bus_req_type = 3'b000;
      cycle();
      check("t6_grant", bus_grant, 3'b000);
      check("t6_active", bus_active, 1'b0);
      check("t6_to", arb_timeout, 1'b0);
      rst = 1'b0;
      cycle(); check("t6_first", bus_grant, 3'b001);
      bus_req = '0;

      // Randomized traffic with long holds and rare resets.
      for (int n = 0; n < 5000; n++) begin
         bus_req      = N'($urandom_range(0, 7));
         bus_req_type = N'($urandom_range(0, 7));
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 39) == 0) bus_hold[i] = ~bus_hold[i];
         rst = ($urandom_range(0, 599) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/l2_bus_arbiter.md
# l2_bus_arbiter

Round-robin arbiter for one shared 38-bit tri-state L2 bus segment; one instance per bus (bus 0 request/address, bus 1 data/reply). Requesters are the per-core L1 interfaces and the L2 cache. Each raises `bus_req`/`bus_req_type`/`bus_hold`; the arbiter returns a one-hot registered `bus_grant` and a common `bus_active`. Snoopers use `bus_active & ~bus_grant` to detect a foreign transfer. One idle turnaround cycle is enforced between owners so two tri-state drivers never overlap.

## Interface
- `NUM_MASTERS`, 3: number of requesters; index 0/1 = core L1s, 2 = L2.
- `OWNER_WIDTH`, 2: width of `bus_owner`; must be ≥ clog2(`NUM_MASTERS`).
- `BURST_BEATS`, 4: data beats following the header in a burst tenure.
- `MAX_TENURE`, 64: watchdog limit in grant cycles; must be ≥ `BURST_BEATS`+1.
- `plusclk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bus_req`  in  `NUM_MASTERS`  level request, held until granted.
- `bus_req_type`  in  `NUM_MASTERS`  0 = single beat (header only), 1 = burst (header + `BURST_BEATS`); sampled only in the cycle the grant is issued.
- `bus_hold`  in  `NUM_MASTERS`  owner extends tenure beyond its minimum length.
- `bus_grant`  out  `NUM_MASTERS`  one-hot or zero, registered.
- `bus_active`  out  1  OR of `bus_grant`, registered.
- `bus_owner`  out  `OWNER_WIDTH`  index of current grantee; holds last owner when idle.
- `arb_timeout`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- States: IDLE, GRANT, TURN.
- IDLE: if any `bus_req`, pick the winner with the rotating priority picker. On the next edge, set that grant bit, `bus_active`=1, load `bus_owner`, latch `min_len` (1 for single, `BURST_BEATS`+1 for burst), set `tenure_cnt`=1, and go to GRANT.
- Rotating priority: search starts at (last owner + 1) mod `NUM_MASTERS`. The pointer updates only when a grant is issued.
- GRANT: `tenure_cnt` increments each cycle and saturates at `MAX_TENURE`.
  - Release when `tenure_cnt` ≥ `min_len` and `bus_hold[owner]`=0: go to TURN.
  - Forced release when `tenure_cnt`==`MAX_TENURE`, regardless of hold: go to TURN and pulse `arb_timeout`.
  - `bus_req`, `bus_req_type` and `bus_hold` of non-owners are ignored in GRANT.
- TURN: lasts exactly one cycle with `bus_grant`=0 and `bus_active`=0. Arbitration is evaluated in this cycle. If there is a winner, go directly to GRANT on the next edge; otherwise go to IDLE.
- A request dropped before its grant is simply lost; there is no memory of it.
- If the owner re-requests at release, it has lowest priority. If it is the only requester, it is re-granted after TURN.
- `bus_hold` asserted before `min_len` is reached has no effect until `min_len` is reached.
- `tenure_cnt` width is clog2(`MAX_TENURE`+1). Comparisons are unsigned.

## Timing
- Reset values: `bus_grant`=0, `bus_active`=0, `bus_owner`=0, `arb_timeout`=0, state IDLE, rotating priority pointer → index 0 searched first, `tenure_cnt`=0.
- Reset asserted mid-tenure: grant drops on that same edge, with no TURN cycle and no timeout pulse.
- Request-to-grant latency from IDLE is 1 cycle: `bus_req` seen at edge k gives grant visible after edge k.
- Single tenure with no hold is 1 grant cycle. Burst tenure with no hold is `BURST_BEATS`+1 = 5 grant cycles.
- Owner-to-owner gap is exactly 1 dead cycle (TURN).
- Maximum grant length is `MAX_TENURE` cycles.
- `arb_timeout` is high during the TURN cycle that follows the forced release.
- `bus_grant` and `bus_active` change only on `plusclk` edges; there is no combinational path from inputs to outputs.

## Structure
- Shared package `l2_bus_pkg`:
  - state encoding IDLE/GRANT/TURN;
  - `REQ_SINGLE`=1'b0, `REQ_BURST`=1'b1;
  - default `BURST_BEATS`.
- `l2_bus_arbiter` instantiates one sub-module `rr_priority_picker`. It is combinational and parameterized by `NUM_MASTERS`.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot winner, winner index and `any` flag.
- One instance per bus. In the L2 top, bus 0 and bus 1 each get their own arbiter.

## Test plan
- Reset, then `bus_req`=3'b011, both type 0, no hold, held until granted:
  - grant 001 for 1 cycle;
  - TURN with 000 and `bus_active`=0;
  - grant 010 for 1 cycle;
  - return to IDLE after TURN.
- `bus_req`=3'b100 type 1, no hold: grant 100 for exactly 5 cycles, `bus_owner`=2, then 1 dead cycle.
- Burst owner 2 holds `bus_hold[2]`=1 until grant cycle 8: grant lasts 8 cycles.
  - `bus_req`=3'b001 waiting throughout stays ungranted until after TURN, then gets grant 001.
- Requester 1 with `bus_hold[1]` stuck at 1: grant drops after 64 cycles, `arb_timeout` pulses once in the TURN cycle, then requester 0 is served.
- Fairness: all three requesting continuously, type 0 → grant order 001, 010, 100, 001, with one dead cycle between each.
- `rst` asserted in burst cycle 3:
  - next edge shows `bus_grant`=0, `bus_active`=0, `arb_timeout`=0;
  - after reset with 3'b111 pending, requester 0 wins first.
